// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, ALU and
// extender codes, opcodes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLASS_ADDR,
    ALU_CLASS_BRANCH,
    ALU_CLASS_OP
  } alu_class_t;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [3:0] IMM_I   = 4'd0;
  localparam logic [3:0] IMM_S   = 4'd1;
  localparam logic [3:0] IMM_B   = 4'd2;
  localparam logic [3:0] IMM_J   = 4'd3;
  localparam logic [3:0] IMM_U   = 4'd4;
  localparam logic [3:0] IMM_LB  = 4'd5;
  localparam logic [3:0] IMM_LH  = 4'd6;
  localparam logic [3:0] IMM_LW  = 4'd7;
  localparam logic [3:0] IMM_LBU = 4'd8;
  localparam logic [3:0] IMM_LHU = 4'd9;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_RESULT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_LOAD      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_SRCB      = 2'b11;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_A        = 2'b10;
  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;

  // Extender mode for the load data in write-back; unknown widths fall back to a word.
  function automatic logic [3:0] load_imm_src(input logic [2:0] funct3);
    logic [3:0] mode;
    case (funct3)
      3'b000:  mode = IMM_LB;
      3'b001:  mode = IMM_LH;
      3'b100:  mode = IMM_LBU;
      3'b101:  mode = IMM_LHU;
      default: mode = IMM_LW;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the
// datapath/memory side (slave).
interface multicycle_control_unit_if;
  logic [31:0] instr;
  logic        Zero;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        RegSrc;
  logic        ImmIn;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [3:0]  ImmSrc;
  logic [3:0]  ALUControl;
  logic [3:0]  state_o;

  modport master (
    input  instr, Zero,
    output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmIn,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state_o
  );

  modport slave (
    output instr, Zero,
    input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, RegSrc, ImmIn,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state_o
  );
endinterface

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU function select: address arithmetic always adds, branches compare,
// register/immediate ops decode funct3 with funct7[5] as the SUB/SRA modifier.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        is_rtype,
  input  alu_class_t  alu_class,
  output logic [3:0]  alu_control
);

  // OP-IMM has no SUBI, so funct7[5] only matters there for SRAI.
  logic alt_op;
  assign alt_op = funct7b5 && (is_rtype || funct3 == 3'b101);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_class)
      ALU_CLASS_BRANCH: begin
        case (funct3[2:1])
          2'b10:   alu_control = ALU_SLT;
          2'b11:   alu_control = ALU_SLTU;
          default: alu_control = ALU_SUB;
        endcase
      end
      ALU_CLASS_OP: begin
        case (funct3)
          3'b000:  alu_control = alt_op ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = alt_op ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle RV32I datapath: Moore decode of state and
// instruction into datapath selects/enables; branch PCWrite also follows Zero.
module multicycle_control_unit
  import ctrl_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus
);

  state_t     state, state_next;
  alu_class_t alu_class;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       pc_write, ir_write, reg_write, mem_write;
  logic       branch_taken;
  logic       unused_instr_bits;

  assign opcode            = bus.instr[6:0];
  assign funct3            = bus.instr[14:12];
  assign funct7b5          = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // 010/011 are not branch encodings; the rest alternate Zero polarity by funct3[2] and funct3[0].
  always_comb begin
    case (funct3)
      3'b010, 3'b011: branch_taken = 1'b0;
      default:        branch_taken = bus.Zero ^ funct3[2] ^ funct3[0];
    endcase
  end

  always_comb begin
    state_next    = S_FETCH;
    alu_class     = ALU_CLASS_ADDR;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_write     = 1'b0;
    bus.AdrSrc    = ADR_PC;
    bus.RegSrc    = 1'b0;
    bus.ImmIn     = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_B;
    bus.ImmSrc    = IMM_I;
    case (state)
      S_FETCH: begin
        ir_write      = 1'b1;
        pc_write      = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        state_next    = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (opcode)
          OP_BRANCH:        bus.ImmSrc = IMM_B;
          OP_JAL:           bus.ImmSrc = IMM_J;
          OP_LUI, OP_AUIPC: bus.ImmSrc = IMM_U;
          default:          bus.ImmSrc = IMM_I;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXECR;
          OP_IMM:            state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_ALUWB;
          default:           state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_next  = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = ADR_RESULT;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        // Address stays on Result so the load data remains presented to the extender.
        bus.AdrSrc    = ADR_RESULT;
        bus.ImmIn     = 1'b1;
        bus.ImmSrc    = load_imm_src(funct3);
        bus.ResultSrc = RES_LOAD;
        reg_write     = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc = ADR_RESULT;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        bus.ALUSrcA = SRCA_A;
        alu_class   = ALU_CLASS_OP;
        state_next  = S_ALUWB;
      end
      S_EXECI: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
        alu_class   = ALU_CLASS_OP;
        state_next  = S_ALUWB;
      end
      S_ALUWB:  reg_write = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcA = SRCA_A;
        alu_class   = ALU_CLASS_BRANCH;
        pc_write    = branch_taken;
      end
      S_JAL: begin
        bus.RegSrc = 1'b1;
        reg_write  = 1'b1;
        pc_write   = 1'b1;
      end
      S_JALR: begin
        bus.ALUSrcA   = SRCA_A;
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        bus.RegSrc    = 1'b1;
        reg_write     = 1'b1;
        pc_write      = 1'b1;
      end
      S_LUI: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ImmSrc    = IMM_U;
        bus.ResultSrc = RES_SRCB;
        reg_write     = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .is_rtype    (opcode == OP_R),
    .alu_class   (alu_class),
    .alu_control (bus.ALUControl)
  );

  // Reset kills every architectural write at once, independent of the clock.
  assign bus.PCWrite  = pc_write  & ~reset;
  assign bus.IRWrite  = ir_write  & ~reset;
  assign bus.RegWrite = reg_write & ~reset;
  assign bus.MemWrite = mem_write & ~reset;
  assign bus.state_o  = state;

endmodule
